// File: rtl/coin_acceptor.sv
// Coin front-end: synchronises and debounces the Rs1/Rs2/Rs5 detectors and emits one
// registered strobe per coin, either coin_valid with its code or reject to the chute.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sens_rs1,
  input  logic             sens_rs2,
  input  logic             sens_rs5,
  input  logic             hold,
  output logic [2:0]       coin_code,
  output logic             coin_valid,
  output logic             reject,
  output logic [CNT_W-1:0] reject_cnt
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, RELEASE, GAP} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [2:0]       sync_p0;
  logic [2:0]       sync_p1;
  logic [2:0]       cap;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       v;

  assign v = sync_p1;

  function automatic logic [2:0] encode(input logic [2:0] c);
    case (c)
      3'b001:  encode = 3'b001;
      3'b010:  encode = 3'b010;
      3'b100:  encode = 3'b101;
      default: encode = 3'b000;
    endcase
  endfunction

  function automatic logic is_one_hot(input logic [2:0] c);
    is_one_hot = (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    sat_inc = (&x) ? x : x + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sync_p0    <= '0;
      sync_p1    <= '0;
      cap        <= '0;
      cnt        <= '0;
      coin_code  <= '0;
      coin_valid <= 1'b0;
      reject     <= 1'b0;
      reject_cnt <= '0;
    end else begin
      // synchroniser stages
      sync_p0    <= {sens_rs5, sens_rs2, sens_rs1};
      sync_p1    <= sync_p0;
      coin_code  <= '0;
      coin_valid <= 1'b0;
      reject     <= 1'b0;
      case (state)
        IDLE: begin
          if (v != 3'b000) begin
            cap   <= v;
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (v == 3'b000) begin
            state <= IDLE;
          end else if (v != cap) begin
            cap <= v;
            cnt <= '0;
          end else if (cnt != DEB_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            // hold is only looked at on this decision edge
            if (is_one_hot(cap) && !hold) begin
              coin_valid <= 1'b1;
              coin_code  <= encode(cap);
            end else begin
              reject     <= 1'b1;
              reject_cnt <= sat_inc(reject_cnt);
            end
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (v == 3'b000) begin
            cnt   <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) state <= IDLE;
          else                 cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
